// File: rtl/driver_rx.sv
// LED-driver serial link receiver: recovers channel words from dck/dai/lat.
// Optional dck inactivity abort: define DRIVER_RX_TIMEOUT_EN.
module driver_rx #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_timeout   = 4096
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_dck,
    input  logic                                 i_dai,
    input  logic                                 i_lat,
    output logic                                 o_wen,
    output logic [$clog2(c_ledboards*32)-1:0]    o_addr,
    output logic [c_bpc-1:0]                     o_data,
    output logic                                 o_frame,
    output logic                                 o_err,
    output logic [$clog2(c_ledboards*32+1)-1:0]  o_count
);

    localparam int c_channels = c_ledboards * 32;
    localparam int AW = $clog2(c_channels);
    localparam int CW = $clog2(c_channels + 1);
    localparam int BW = $clog2(c_bpc);

    logic dck_m_q, dck_m_d, dck_s_q, dck_s_d, dck_p_q, dck_p_d;
    logic lat_m_q, lat_m_d, lat_s_q, lat_s_d, lat_p_q, lat_p_d;
    logic dai_m_q, dai_m_d, dai_s_q, dai_s_d;

    logic [c_bpc-1:0] sh_q, sh_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic             ovf_q, ovf_d;

    logic             wr_pend_q, wr_pend_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [c_bpc-1:0] wr_data_q, wr_data_d;
    logic             frm_pend_q, frm_pend_d;
    logic             err_pend_q, err_pend_d;
    logic [CW-1:0]    cnt_hold_q, cnt_hold_d;

    logic             o_wen_q, o_wen_d;
    logic [AW-1:0]    o_addr_q, o_addr_d;
    logic [c_bpc-1:0] o_data_q, o_data_d;
    logic             o_frame_q, o_frame_d;
    logic             o_err_q, o_err_d;
    logic [CW-1:0]    o_count_q, o_count_d;

    logic dck_rise, lat_rise;

`ifdef DRIVER_RX_TIMEOUT_EN
    localparam int TW = $clog2(c_timeout + 1);
    logic [TW-1:0] idle_q, idle_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^c_timeout;
`endif

    assign dck_rise = dck_s_q & ~dck_p_q;
    assign lat_rise = lat_s_q & ~lat_p_q;

    always_comb begin
        dck_m_d = i_dck;
        dck_s_d = dck_m_q;
        dck_p_d = dck_s_q;
        lat_m_d = i_lat;
        lat_s_d = lat_m_q;
        lat_p_d = lat_s_q;
        dai_m_d = i_dai;
        dai_s_d = dai_m_q;

        sh_d       = sh_q;
        bit_d      = bit_q;
        wcnt_d     = wcnt_q;
        ovf_d      = ovf_q;
        wr_pend_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        frm_pend_d = frm_pend_q;
        err_pend_d = err_pend_q;
        cnt_hold_d = cnt_hold_q;

        o_wen_d   = wr_pend_q;
        o_addr_d  = o_addr_q;
        o_data_d  = o_data_q;
        o_frame_d = 1'b0;
        o_err_d   = 1'b0;
        o_count_d = o_count_q;

        // A pending write always goes first; the strobe waits a cycle.
        if (wr_pend_q) begin
            o_addr_d = wr_addr_q;
            o_data_d = wr_data_q;
        end else if (frm_pend_q || err_pend_q) begin
            o_frame_d  = frm_pend_q;
            o_err_d    = err_pend_q;
            o_count_d  = cnt_hold_q;
            frm_pend_d = 1'b0;
            err_pend_d = 1'b0;
        end

        if (dck_rise) begin
            sh_d = {sh_q[c_bpc-2:0], dai_s_q};
            if (bit_q == BW'(c_bpc - 1)) begin
                bit_d = '0;
                if (wcnt_q != CW'(c_channels)) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = sh_d;
                    wr_addr_d = AW'(c_channels - 1) - AW'(wcnt_q);
                    wcnt_d    = wcnt_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end

`ifdef DRIVER_RX_TIMEOUT_EN
        idle_d = idle_q;
        if (dck_rise || lat_rise || bit_q == '0) begin
            idle_d = '0;
        end else if (idle_q == TW'(c_timeout - 1)) begin
            idle_d = '0;
            bit_d  = '0;
            sh_d   = '0;
            ovf_d  = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
`endif

        // Latch judges the counters after any same-cycle bit.
        if (lat_rise) begin
            if (wcnt_d == CW'(c_channels) && bit_d == '0 && !ovf_d)
                frm_pend_d = 1'b1;
            else
                err_pend_d = 1'b1;
            cnt_hold_d = wcnt_d;
            bit_d      = '0;
            wcnt_d     = '0;
            sh_d       = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dck_m_q    <= 1'b0;
            dck_s_q    <= 1'b0;
            dck_p_q    <= 1'b0;
            lat_m_q    <= 1'b0;
            lat_s_q    <= 1'b0;
            lat_p_q    <= 1'b0;
            dai_m_q    <= 1'b0;
            dai_s_q    <= 1'b0;
            sh_q       <= '0;
            bit_q      <= '0;
            wcnt_q     <= '0;
            ovf_q      <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frm_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            cnt_hold_q <= '0;
            o_wen_q    <= 1'b0;
            o_addr_q   <= '0;
            o_data_q   <= '0;
            o_frame_q  <= 1'b0;
            o_err_q    <= 1'b0;
            o_count_q  <= '0;
`ifdef DRIVER_RX_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            dck_m_q    <= dck_m_d;
            dck_s_q    <= dck_s_d;
            dck_p_q    <= dck_p_d;
            lat_m_q    <= lat_m_d;
            lat_s_q    <= lat_s_d;
            lat_p_q    <= lat_p_d;
            dai_m_q    <= dai_m_d;
            dai_s_q    <= dai_s_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            wcnt_q     <= wcnt_d;
            ovf_q      <= ovf_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            frm_pend_q <= frm_pend_d;
            err_pend_q <= err_pend_d;
            cnt_hold_q <= cnt_hold_d;
            o_wen_q    <= o_wen_d;
            o_addr_q   <= o_addr_d;
            o_data_q   <= o_data_d;
            o_frame_q  <= o_frame_d;
            o_err_q    <= o_err_d;
            o_count_q  <= o_count_d;
`ifdef DRIVER_RX_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign o_wen   = o_wen_q;
    assign o_addr  = o_addr_q;
    assign o_data  = o_data_q;
    assign o_frame = o_frame_q;
    assign o_err   = o_err_q;
    assign o_count = o_count_q;

endmodule

// File: tb/tb_driver_rx.sv
// Bench for driver_rx: random serial frames against a bit-stream model,
// writes and latch strobes checked through scoreboard queues.
module tb_driver_rx;

    localparam int C   = 32;
    localparam int BPC = 12;
    localparam int TO  = 100;

    logic        clk, rst, dck, dai, lat;
    logic        o_wen, o_frame, o_err;
    logic [4:0]  o_addr;
    logic [11:0] o_data;
    logic [5:0]  o_count;

    driver_rx #(
        .c_ledboards(1),
        .c_bpc(BPC),
        .c_timeout(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_dck(dck),
        .i_dai(dai),
        .i_lat(lat),
        .o_wen(o_wen),
        .o_addr(o_addr),
        .o_data(o_data),
        .o_frame(o_frame),
        .o_err(o_err),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [11:0] data;
    } wr_t;

    typedef struct {
        logic       frame;
        logic [5:0] count;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the received bit stream of the current frame.
    int          bit_n = 0;
    logic [11:0] cur = '0;
    int          words = 0;
    bit          bad = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        bit_n = 0;
        cur   = '0;
        words = 0;
        bad   = 1'b0;
    endtask

    task automatic model_bit(input logic b);
        wr_t e;
        cur = {cur[10:0], b};
        bit_n++;
        if (bit_n == BPC) begin
            bit_n = 0;
            if (words < C) begin
                e.addr = 5'(C - 1 - words);
                e.data = cur;
                wr_q.push_back(e);
            end
            words++;
        end
    endtask

    task automatic send_bit(input logic b, input int h, input bit meas);
        int first;
        @(negedge clk);
        dai = b;
        model_bit(b);
        repeat (h) @(negedge clk);
        dck = 1'b1;
        if (meas) begin
            first = 0;
            for (int k = 1; k <= h; k++) begin
                @(negedge clk);
                if (o_wen && first == 0) first = k;
            end
            chk("wen_latency", first, 4);
        end else begin
            repeat (h) @(negedge clk);
        end
        dck = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w, input int hmin,
                             input int hmax, input bit meas);
        for (int i = BPC - 1; i >= 0; i--)
            send_bit(w[i], int'($urandom_range(hmax, hmin)),
                     meas && i == 0);
    endtask

    task automatic send_rand_words(input int n);
        for (int i = 0; i < n; i++)
            send_word(12'($urandom), 3, 6, 1'b0);
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++)
            send_bit(1'($urandom), int'($urandom_range(6, 3)), 1'b0);
    endtask

    task automatic latch();
        st_t s;
        @(negedge clk);
        lat = 1'b1;
        s.frame = (words == C && bit_n == 0 && !bad);
        s.count = 6'((words > C) ? C : words);
        st_q.push_back(s);
        model_clear();
        repeat (4) @(negedge clk);
        lat = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
`ifdef DRIVER_RX_TIMEOUT_EN
        if (bit_n != 0 && n > TO + 10) begin
            bit_n = 0;
            cur   = '0;
            bad   = 1'b1;
        end
`endif
    endtask

    always @(negedge clk) begin
        wr_t e;
        st_t s;
        if (!rst) begin
            if (o_wen) begin
                chk("wen_excl", {31'b0, o_frame | o_err}, 0);
                if (wr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_wen: got addr=%0d data=%0h expected none",
                             o_addr, o_data);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", {27'b0, o_addr}, {27'b0, e.addr});
                    chk("wr_data", {20'b0, o_data}, {20'b0, e.data});
                end
            end
            if (o_frame || o_err) begin
                chk("strobe_excl", {31'b0, o_frame & o_err}, 0);
                if (st_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got frame=%0b err=%0b expected none",
                             o_frame, o_err);
                end else begin
                    s = st_q.pop_front();
                    chk("frame", {31'b0, o_frame}, {31'b0, s.frame});
                    chk("err", {31'b0, o_err}, {31'b0, !s.frame});
                    chk("count", {26'b0, o_count}, {26'b0, s.count});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        dck = 1'b0;
        dai = 1'b0;
        lat = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {6'b0, o_wen, o_frame, o_err, o_addr, o_data, o_count}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Ascending words at the slow link rate, then a clean latch.
        for (int w = 0; w < C; w++)
            send_word(12'(w), 25, 25, w == 0);
        latch();

        // Overrun frame, then a clean one.
        send_rand_words(C + 1);
        latch();
        send_rand_words(C);
        latch();

        // Short frame with a partial word, then a clean one.
        send_rand_words(C - 1);
        send_rand_bits(5);
        latch();
        send_rand_words(C);
        latch();

        // Reset mid-frame discards it.
        send_rand_words(10);
        repeat (10) @(negedge clk);
        chk("pre_reset_drain", wr_q.size(), 0);
        rst = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        chk("midframe_reset_outputs",
            {6'b0, o_wen, o_frame, o_err, o_addr, o_data, o_count}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_rand_words(C);
        latch();

        // Stray bits followed by a long idle gap.
        send_rand_bits(7);
        idle(150);
        send_rand_words(C);
        latch();
        send_rand_words(C);
        latch();

        repeat (20) @(negedge clk);
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("strobe_queue_empty", st_q.size(), 0);
        chk("count_hold", {26'b0, o_count}, 32);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/driver_rx.md
Name: driver_rx

Overview:
- Receiving end of the LED-driver serial link: deserializes the clock/data/latch stream produced by the driver block back into per-channel words.
- Used as a chain-emulating sink for verification, and to loop back and monitor the physical output on the board.
- Writes recovered words into a framebuffer-style write port.
- Pulses a frame strobe on each well-formed latch, or an error strobe on a malformed one.

Parameters:
c_ledboards, 30, number of LED boards in the chain (32 channels each)
c_bpc, 12, bits per channel word
c_timeout, 4096, i_clk cycles of dck inactivity that abort a partial word (used only with the optional feature)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  asynchronous active-high reset
i_dck  input  1  serial clock from the driver (asynchronous to i_clk)
i_dai  input  1  serial data, valid at rising i_dck
i_lat  input  1  latch, asynchronous
o_wen  output  1  one-cycle write strobe
o_addr  output  $clog2(c_ledboards*32)  channel address of o_data
o_data  output  c_bpc  recovered channel word
o_frame  output  1  one-cycle pulse: well-formed frame latched
o_err  output  1  one-cycle pulse: malformed frame latched
o_count  output  $clog2(c_ledboards*32+1)  words received in the frame just latched; valid with o_frame/o_err, held until the next latch

Behaviour:
- c_channels = c_ledboards*32.
- Reset (async, i_rst=1): all outputs 0; shift register, bit counter, word counter, synchronizers and overrun flag cleared.
- Input conditioning:
  - i_dck, i_dai and i_lat each pass through a 2-FF synchronizer, then a 1-FF previous-value register.
  - Rising edge = sync=1 and prev=0; one-cycle event.
  - i_dai is sampled from its synchronizer stage on the dck edge event. Input i_dck must therefore stay high and low ≥3 i_clk cycles each; the driver's 2 MHz link satisfies this at 100 MHz.
- Bit path:
  - On each dck edge, shift the i_dai sample into the LSB; the word is received MSB first.
  - Bit counter 0..c_bpc-1; it wraps to 0 when a word completes.
- Word complete (the c_bpc-th bit):
  - If word count < c_channels: next cycle o_wen=1, o_data = word, o_addr = c_channels-1-word count. The first word shifted belongs to the last board in the chain, so addresses descend. Word count then increments.
  - If word count == c_channels: no write; set the sticky overrun flag; word count saturates.
- Latency: o_wen asserts exactly 4 i_clk cycles after the i_dck rising edge carrying the last bit: 2 sync stages + edge detect + output register.
- Latch, on the lat rising-edge event:
  - Well-formed (word count == c_channels, bit counter == 0, overrun clear): o_frame=1 for one cycle.
  - Otherwise: o_err=1 for one cycle.
  - Both cases: o_count = word count, and bit counter, word count, shift register and overrun flag clear.
  - A word completing in the same cycle as the latch is still written. The latch evaluation uses the post-increment count.
- Simultaneous dck edge and lat edge in the same cycle:
  - The bit is shifted first; the latch then applies using the updated counters.
  - A partial word is always an error.
- o_frame and o_err are never both 1. o_wen never asserts in the same cycle as either.
- Reset mid-word or mid-frame discards everything; there is no write or strobe on deassertion.
- i_lat held high: only the edge acts; dck edges during a high latch are received normally into the next frame.

Optional Feature:
- Macro DRIVER_RX_TIMEOUT_EN.
- Defined:
  - An idle counter counts i_clk cycles since the last dck edge while bit counter != 0.
  - On reaching c_timeout: discard the partial word and clear the bit counter. Word count is unchanged and the overrun flag is set, so the next latch gives o_err.
  - The counter resets on every dck edge and every lat edge.
- Undefined: no idle counter; a partial word waits indefinitely.

Test Plan:
- c_ledboards=1, c_bpc=12. Shift 32 words 0x000..0x01F, MSB first, at 1/50 i_clk rate, then a lat pulse -> 32 o_wen pulses: first at o_addr=31 with o_data=0x000, last at o_addr=0 with o_data=0x01F. o_frame=1 once, o_count=32, o_err never.
- Time the last bit edge of word 0 -> o_wen exactly 4 cycles after the synchronized i_dck rise at the input pin.
- 33 words then lat -> 32 writes only, o_err=1, o_count=32, o_frame=0. A following clean 32-word frame -> o_frame=1.
- 31 words + 5 bits then lat -> o_err=1, o_count=31. The next frame starts at o_addr=31.
- Assert i_rst after 10 words, release, send a clean frame -> no strobe from the aborted frame; next frame o_frame=1, o_count=32.
- With DRIVER_RX_TIMEOUT_EN and c_timeout=100: send 7 bits, idle 150 cycles, then 32 full words, then lat -> o_err=1, o_count=32. Without the macro: the same stimulus gives misaligned words and o_err=1 with o_count=32.
